// File: rtl/aes_pipe_hs.sv
// aes_pipe_hs: AES-128 encryption pipeline, ROUNDS_PER_STAGE rounds per stage, valid/ready handshake, global stall.
// Define AES_PIPE_FLUSH_EN to add a flush input that drops every in-flight block.
module aes_pipe_hs #(
  parameter int ROUNDS_PER_STAGE = 1,
  parameter int TAG_W = 8,
  localparam int S = 10 / ROUNDS_PER_STAGE,
  localparam int CNT_W = $clog2(S + 2)
) (
  input  logic             clk,
  input  logic             reset,
`ifdef AES_PIPE_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     data_in,
  input  logic [127:0]     key,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     cryptokey,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] in_flight
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input int rnd);
    case (rnd)
      1: return 8'h01;
      2: return 8'h02;
      3: return 8'h04;
      4: return 8'h08;
      5: return 8'h10;
      6: return 8'h20;
      7: return 8'h40;
      8: return 8'h80;
      9: return 8'h1b;
      10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Byte n of the block sits at bits [127-8n -: 8]; row r of column c is byte 4c+r.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = SBOX[s[127-8*(4*((c+r)%4)+r) -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input int rnd);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {SBOX[k[23:16]] ^ rcon(rnd), SBOX[k[15:8]], SBOX[k[7:0]], SBOX[k[31:24]]};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Round keys are expanded on the fly alongside the state, so each slot carries its current round key.
  function automatic logic [255:0] run_stage(input logic [127:0] s, input logic [127:0] k, input int first);
    logic [127:0] st, rk, sr;
    st = s;
    rk = k;
    for (int j = 0; j < ROUNDS_PER_STAGE; j++) begin
      rk = next_key(rk, first + j);
      sr = sub_shift(st);
      st = (((first + j) == 10) ? sr : mix(sr)) ^ rk;
    end
    return {st, rk};
  endfunction

  logic [S:0]       r_valid;
  logic [127:0]     r_state [0:S];
  logic [127:0]     r_rkey  [0:S];
  logic [TAG_W-1:0] r_tag   [0:S];
  logic [CNT_W-1:0] r_cnt;
  logic [127:0]     w_nstate [1:S];
  logic [127:0]     w_nkey   [1:S];
  logic             w_adv, w_accept, w_out_hs;

  for (genvar g = 1; g <= S; g++) begin : g_stage
    assign {w_nstate[g], w_nkey[g]} = run_stage(r_state[g-1], r_rkey[g-1], (g - 1) * ROUNDS_PER_STAGE + 1);
  end

  assign w_adv    = ~r_valid[S] | out_ready;
`ifdef AES_PIPE_FLUSH_EN
  assign in_ready = w_adv & ~flush;
`else
  assign in_ready = w_adv;
`endif
  assign w_accept = in_valid & in_ready;
  assign w_out_hs = r_valid[S] & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_cnt   <= '0;
      for (int i = 0; i <= S; i++) begin
        r_state[i] <= '0;
        r_rkey[i]  <= '0;
        r_tag[i]   <= '0;
      end
    end
`ifdef AES_PIPE_FLUSH_EN
    else if (flush) begin
      r_valid <= '0;
      r_cnt   <= '0;
    end
`endif
    else if (w_adv) begin
      r_valid    <= {r_valid[S-1:0], w_accept};
      r_state[0] <= data_in ^ key;
      r_rkey[0]  <= key;
      r_tag[0]   <= in_tag;
      for (int i = 1; i <= S; i++) begin
        r_state[i] <= w_nstate[i];
        r_rkey[i]  <= w_nkey[i];
        r_tag[i]   <= r_tag[i-1];
      end
      r_cnt <= r_cnt + CNT_W'(w_accept) - CNT_W'(w_out_hs);
    end
  end

  assign out_valid = r_valid[S];
  assign cryptokey = r_state[S];
  assign out_tag   = r_tag[S];
  assign in_flight = r_cnt;

endmodule
